// File: rtl/pdiv32_pkg.sv
// pdiv32_pkg: shared constants for the 32-bit iterative divider.
//   WIDTH  - operand/result width
//   ITER   - restoring steps per division
//   CNT_W  - iteration counter width (holds 0..ITER)
//   ST_*   - FSM state encodings
package pdiv32_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = $clog2(ITER + 1);

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_FIXUP   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

endpackage : pdiv32_pkg

// File: rtl/pdiv_step.sv
// pdiv_step: one combinational restoring-division step.
//   rem_i/quo_i  - current partial remainder (33 bits) and quotient shift register
//   dvs_i        - divisor magnitude
//   rem_o/quo_o  - remainder and quotient after shift, trial subtract and bit select
module pdiv_step
  import pdiv32_pkg::*;
(
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH+1:0] shifted_c;
  logic [WIDTH+1:0] diff_c;
  logic             fits_c;

  // One guard bit above the 33-bit remainder keeps the borrow visible even
  // for full-range unsigned divisors.
  always_comb begin
    shifted_c = {rem_i, quo_i[WIDTH-1]};
    diff_c    = shifted_c - {2'b00, dvs_i};
    fits_c    = ~diff_c[WIDTH+1];
    rem_o     = fits_c ? diff_c[WIDTH:0] : shifted_c[WIDTH:0];
    quo_o     = {quo_i[WIDTH-2:0], fits_c};
  end

endmodule : pdiv_step

// File: rtl/pdiv32.sv
// pdiv32: 32-bit restoring divider, fixed 34-clock latency, signed by default.
//   clk, rst_n      - clock, asynchronous active-low reset
//   start           - one-cycle launch pulse (ignored while busy)
//   dividend/divisor- operands, sampled on the start edge
//   op              - 1 signed / 0 unsigned; honoured only with PDIV32_SIGNED_OP_EN
//   q, r            - registered quotient / remainder, held in DONE
//   done, busy, dbz - status flags (dbz marks divide-by-zero results)
// Build option: define PDIV32_SIGNED_OP_EN to enable unsigned mode via op.
module pdiv32
  import pdiv32_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             op,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             done,
  output logic             busy,
  output logic             dbz
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             dbz_q, dbz_d;

  logic             signed_c;
  logic             a_neg_c, b_neg_c;
  logic [WIDTH:0]   step_rem_c;
  logic [WIDTH-1:0] step_quo_c;

  // Mode select: op only matters when unsigned mode is compiled in.
`ifdef PDIV32_SIGNED_OP_EN
  assign signed_c = op;
`else
  assign signed_c = op | 1'b1;
`endif

  assign a_neg_c = signed_c & dividend[WIDTH-1];
  assign b_neg_c = signed_c & divisor[WIDTH-1];

  pdiv_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem_c),
    .quo_o (step_quo_c)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    zero_d  = zero_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUNNING;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = a_neg_c ? (~dividend + 32'd1) : dividend;
          dvs_d   = b_neg_c ? (~divisor + 32'd1) : divisor;
          dvd_d   = dividend;
          negq_d  = a_neg_c ^ b_neg_c;
          negr_d  = a_neg_c;
          zero_d  = (divisor == '0);
          q_d     = '0;
          r_d     = '0;
          dbz_d   = 1'b0;
        end
      end
      ST_RUNNING: begin
        if (cnt_q == CNT_W'(ITER)) begin
          state_d = ST_FIXUP;
        end else begin
          rem_d = step_rem_c;
          quo_d = step_quo_c;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FIXUP: begin
        state_d = ST_DONE;
        // Divide-by-zero overrides the sign correction entirely.
        if (zero_q) begin
          q_d   = '1;
          r_d   = dvd_q;
          dbz_d = 1'b1;
        end else begin
          q_d = negq_q ? (~quo_q + 32'd1) : quo_q;
          r_d = negr_q ? (~rem_q[WIDTH-1:0] + 32'd1) : rem_q[WIDTH-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase

    done_d = (state_d == ST_DONE);
    busy_d = (state_d == ST_RUNNING) || (state_d == ST_FIXUP);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      zero_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      zero_q  <= zero_d;
      q_q     <= q_d;
      r_q     <= r_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      dbz_q   <= dbz_d;
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign done = done_q;
  assign busy = busy_q;
  assign dbz  = dbz_q;

endmodule : pdiv32
